// File: rtl/wch_sequencer.sv
// Learning-phase sequencer: walks the update mask lowest-first, kicks the
// weight-change engine, sweeps all M synapse indices, then awaits completion.
module wch_sequencer #(
    parameter int unsigned M   = 784,
    parameter int unsigned N   = 8,
    parameter int unsigned NW  = 3,
    parameter int unsigned TMO = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_learn,
    input  logic [N-1:0]  update_mask,
    input  logic [N-1:0]  dir,
    input  logic          valid_wch,
    output logic          start_wch,
    output logic          spike_hold,
    output logic [9:0]    ip_select,
    output logic [NW-1:0] neuron_sel,
    output logic          busy,
    output logic          done_learn,
    output logic          error
);

    localparam int unsigned CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_KICK,
        S_SWEEP,
        S_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    ip_q, ip_d;
    logic [NW-1:0] nsel_q, nsel_d;
    logic          hold_q, hold_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          found;
    logic [NW-1:0] idx;

    wire last_ip  = (ip_q == 10'(M - 1));
    wire tmo_hit  = (cnt_q == CW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            dir_q   <= '0;
            cnt_q   <= '0;
            ip_q    <= '0;
            nsel_q  <= '0;
            hold_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            ip_q    <= ip_d;
            nsel_q  <= nsel_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Lowest set bit of the pending mask wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && mask_q[i]) begin
                found = 1'b1;
                idx   = NW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_learn) state_d = S_SCAN;
            S_SCAN:  state_d = found ? S_KICK : S_DONE;
            S_KICK:  state_d = S_SWEEP;
            S_SWEEP: if (last_ip) state_d = S_WAIT;
            S_WAIT: begin
                if (valid_wch)    state_d = S_SCAN;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from state_d.
    always_comb begin
        mask_d  = mask_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        ip_d    = ip_q;
        nsel_d  = nsel_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        err_d   = err_q;
        start_d = (state_d == S_KICK);
        done_d  = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start_learn) begin
                    mask_d = update_mask;
                    dir_d  = dir;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                end
            end
            S_SCAN: begin
                ip_d = '0;
                if (found) begin
                    nsel_d = idx;
                    hold_d = dir_q[idx];
                end
            end
            S_KICK: ip_d = 10'd1;
            S_SWEEP: begin
                ip_d  = last_ip ? '0 : ip_q + 10'd1;
                cnt_d = '0;
            end
            S_WAIT: begin
                if (valid_wch) begin
                    mask_d[nsel_q] = 1'b0;
                    cnt_d          = '0;
                end else if (tmo_hit) begin
                    err_d  = 1'b1;
                    mask_d = '0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  busy_d = 1'b0;
            default: ;
        endcase
    end

    assign start_wch  = start_q;
    assign spike_hold = hold_q;
    assign ip_select  = ip_q;
    assign neuron_sel = nsel_q;
    assign busy       = busy_q;
    assign done_learn = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_wch_sequencer.sv
// Randomised bench for wch_sequencer: a cycle-schedule model predicts every
// output per cycle from mask, direction and engine response latencies.
module tb_wch_sequencer;

    localparam int unsigned M   = 784;
    localparam int unsigned N   = 8;
    localparam int unsigned NW  = 3;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_learn;
    logic [N-1:0]  update_mask;
    logic [N-1:0]  dir;
    logic          valid_wch;
    logic          start_wch;
    logic          spike_hold;
    logic [9:0]    ip_select;
    logic [NW-1:0] neuron_sel;
    logic          busy;
    logic          done_learn;
    logic          error;

    wch_sequencer #(.M(M), .N(N), .NW(NW), .TMO(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_learn (start_learn),
        .update_mask (update_mask),
        .dir         (dir),
        .valid_wch   (valid_wch),
        .start_wch   (start_wch),
        .spike_hold  (spike_hold),
        .ip_select   (ip_select),
        .neuron_sel  (neuron_sel),
        .busy        (busy),
        .done_learn  (done_learn),
        .error       (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Engine latency per neuron: cycles after ip_select=M-1; 0 = never answers.
    int lat [N];
    int nk;
    int kc [N];
    int kn [N];
    int kh [N];
    int done_cyc;
    int exp_err;
    int last_n;
    int last_h;

    // Cycle 1 is the first cycle after the accepted start_learn.
    task automatic build_model(input logic [N-1:0] m, input logic [N-1:0] d);
        int c;
        c       = 1;
        nk      = 0;
        exp_err = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i] && exp_err == 0) begin
                kc[nk] = c + 1;
                kn[nk] = i;
                kh[nk] = int'(d[i]);
                nk++;
                if (lat[i] == 0) begin
                    exp_err  = 1;
                    done_cyc = c + 1 + int'(M) + int'(TMO);
                end else begin
                    c = c + 1 + int'(M) + lat[i];
                end
            end
        end
        if (exp_err == 0) done_cyc = c + 1;
    endtask

    task automatic run_test(input string name, input logic [N-1:0] m, input logic [N-1:0] d,
                            input bit abuse, input int rst_off);
        int bad_ip, bad_sw, bad_sel, bad_hold, bad_busy, bad_done, bad_err;
        int n_sw, n_done, cd, cur_n, cur_h, eip, esw;
        bit aborted;
        build_model(m, d);
        bad_ip = 0; bad_sw = 0; bad_sel = 0; bad_hold = 0;
        bad_busy = 0; bad_done = 0; bad_err = 0;
        n_sw = 0; n_done = 0; cd = 0; aborted = 1'b0;
        cur_n = last_n; cur_h = last_h;
        @(negedge clk);
        update_mask = m;
        dir         = d;
        start_learn = 1'b1;
        for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
            @(negedge clk);
            start_learn = 1'b0;
            valid_wch   = 1'b0;
            update_mask = N'($urandom);
            dir         = N'($urandom);
            eip = 0;
            esw = 0;
            for (int j = 0; j < nk; j++) begin
                if (cyc == kc[j]) begin
                    esw   = 1;
                    cur_n = kn[j];
                    cur_h = kh[j];
                end
                if (cyc > kc[j] && cyc <= kc[j] + int'(M) - 1) eip = cyc - kc[j];
            end
            if (int'(ip_select) != eip) bad_ip++;
            if (int'(start_wch) != esw) bad_sw++;
            if (int'(neuron_sel) != cur_n) bad_sel++;
            if (int'(spike_hold) != cur_h) bad_hold++;
            if (int'(busy) != ((cyc <= done_cyc) ? 1 : 0)) bad_busy++;
            if (int'(done_learn) != ((cyc == done_cyc) ? 1 : 0)) bad_done++;
            if (int'(error) != ((cyc >= done_cyc) ? exp_err : 0)) bad_err++;
            if (start_wch === 1'b1) n_sw++;
            if (done_learn === 1'b1) n_done++;
            if (esw == 1) begin
                chk_eq({name, "_kick_nsel"}, 32'(neuron_sel), 32'(cur_n));
                chk_eq({name, "_kick_hold"}, 32'(spike_hold), 32'(cur_h));
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) valid_wch = 1'b1;
            end
            for (int j = 0; j < nk; j++)
                if (cyc == kc[j] + int'(M) - 1 && lat[kn[j]] > 0) cd = lat[kn[j]];
            if (abuse && nk > 0) begin
                if (cyc == kc[0] + 300) start_learn = 1'b1;
                if (cyc == kc[0] + 350) valid_wch = 1'b1;
            end
            if (rst_off > 0 && nk > 0 && cyc == kc[0] + rst_off) begin
                chk_eq({name, "_ip_at_rst"}, 32'(ip_select), 32'(rst_off));
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        chk_eq({name, "_ip_seq_bad"}, bad_ip, 0);
        chk_eq({name, "_start_wch_bad"}, bad_sw, 0);
        chk_eq({name, "_neuron_sel_bad"}, bad_sel, 0);
        chk_eq({name, "_spike_hold_bad"}, bad_hold, 0);
        chk_eq({name, "_busy_bad"}, bad_busy, 0);
        chk_eq({name, "_done_bad"}, bad_done, 0);
        chk_eq({name, "_error_bad"}, bad_err, 0);
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            chk_eq({name, "_rst_outputs"},
                   32'({start_wch, spike_hold, ip_select, neuron_sel, busy, done_learn, error}), 0);
            @(negedge clk);
            chk_eq({name, "_rst_idle"}, 32'({busy, done_learn, start_wch}), 0);
            last_n = 0;
            last_h = 0;
        end else begin
            chk_eq({name, "_start_count"}, n_sw, nk);
            chk_eq({name, "_done_count"}, n_done, 1);
            chk_eq({name, "_error_after"}, 32'(error), 32'(exp_err));
            last_n = cur_n;
            last_h = cur_h;
        end
    endtask

    task automatic set_lat(input int v);
        for (int i = 0; i < N; i++) lat[i] = v;
    endtask

    initial begin
        rst         = 1'b1;
        start_learn = 1'b0;
        valid_wch   = 1'b0;
        update_mask = '0;
        dir         = '0;
        last_n      = 0;
        last_h      = 0;
        repeat (3) @(negedge clk);
        chk_eq("reset_outputs",
               32'({start_wch, spike_hold, ip_select, neuron_sel, busy, done_learn, error}), 0);
        rst = 1'b0;
        @(negedge clk);

        set_lat(6);
        run_test("empty", 8'b0000_0000, 8'b1111_1111, 1'b0, 0);
        run_test("single", 8'b0000_0100, 8'b0000_0100, 1'b0, 0);
        run_test("multi", 8'b1000_0011, 8'b0000_0001, 1'b0, 0);
        set_lat(0);
        run_test("timeout", 8'b0000_0011, 8'b0000_0011, 1'b0, 0);
        set_lat(6);
        run_test("abuse", 8'b0001_0001, 8'b0001_0000, 1'b1, 0);
        run_test("rst_mid", 8'b0000_0110, 8'b0000_0010, 1'b0, 400);
        run_test("after_rst", 8'b0000_0001, 8'b0000_0001, 1'b0, 0);
        set_lat(16);
        run_test("tmo_edge", 8'b0000_1001, 8'b0000_1000, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                lat[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
            run_test("rand", N'($urandom & $urandom), N'($urandom), t[0], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
